uart_rx: RTL

8N1 UART receiver: the downstream counterpart of the transmitter, consuming the serial line it drives. It samples the asynchronous `rx` line through a two-flop synchronizer and validates the start bit at mid-bit. Data bits are taken LSB first at bit centres. Each good byte is presented as a one-cycle `rx_valid` pulse on `rx_data`; a bad stop bit raises a one-cycle `frame_err`.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 130 +++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle of the 8N1 UART receiver: serial line in, byte/status out.
// The receiver takes the master modport; the consumer (and line driver) takes slave.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output rx_busy
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised line, mid-bit start validation,
// LSB-first centre sampling, one-cycle rx_valid / frame_err pulses.
module uart_rx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.master bus
);

  localparam logic [15:0] HALF_COUNT = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic        rx_s1_reg, rx_s2_reg, rx_prev_reg;
  logic [15:0] clk_count_reg, clk_count_next;
  logic [2:0]  bit_index_reg, bit_index_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  data_reg, data_next;
  logic        valid_reg, valid_next;
  logic        ferr_reg, ferr_next;
  logic        bit_wr;

  // Each shift bit only loads when the data-bit sample lands on its own index.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_shift
      assign shift_next[gi] = (bit_wr && (bit_index_reg == 3'(gi))) ? rx_s2_reg : shift_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    clk_count_next = clk_count_reg;
    bit_index_next = bit_index_reg;
    data_next      = data_reg;
    valid_next     = 1'b0;
    ferr_next      = 1'b0;
    bit_wr         = 1'b0;
    case (state_reg)
      IDLE: begin
        clk_count_next = 16'd0;
        bit_index_next = 3'd0;
        if (!rx_s2_reg && rx_prev_reg) state_next = START;
      end
      START: begin
        if (clk_count_reg == HALF_COUNT) begin
          clk_count_next = 16'd0;
          state_next     = rx_s2_reg ? IDLE : DATA;
        end else begin
          clk_count_next = clk_count_reg + 16'd1;
        end
      end
      DATA: begin
        if (clk_count_reg == LAST_COUNT) begin
          clk_count_next = 16'd0;
          bit_wr         = 1'b1;
          if (bit_index_reg == 3'd7) begin
            bit_index_next = 3'd0;
            state_next     = STOP;
          end else begin
            bit_index_next = bit_index_reg + 3'd1;
          end
        end else begin
          clk_count_next = clk_count_reg + 16'd1;
        end
      end
      STOP: begin
        if (clk_count_reg == LAST_COUNT) begin
          clk_count_next = 16'd0;
          state_next     = CLEANUP;
          if (rx_s2_reg) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
          end else begin
            ferr_next  = 1'b1;
          end
        end else begin
          clk_count_next = clk_count_reg + 16'd1;
        end
      end
      CLEANUP: begin
        // Wait out a held-low line so a break cannot look like a fresh start.
        if (rx_s2_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_reg     <= 1'b0;
      rx_s2_reg     <= 1'b0;
      rx_prev_reg   <= 1'b0;
      state_reg     <= IDLE;
      clk_count_reg <= 16'd0;
      bit_index_reg <= 3'd0;
      shift_reg     <= 8'h00;
      data_reg      <= 8'h00;
      valid_reg     <= 1'b0;
      ferr_reg      <= 1'b0;
    end else begin
      rx_s1_reg     <= bus.rx;
      rx_s2_reg     <= rx_s1_reg;
      rx_prev_reg   <= rx_s2_reg;
      state_reg     <= state_next;
      clk_count_reg <= clk_count_next;
      bit_index_reg <= bit_index_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      ferr_reg      <= ferr_next;
    end
  end

  assign bus.rx_data   = data_reg;
  assign bus.rx_valid  = valid_reg;
  assign bus.frame_err = ferr_reg;
  assign bus.rx_busy   = (state_reg != IDLE);

endmodule
